// File: rtl/fb_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : fb_write_arbiter
// Purpose  : Shares the single framebuffer write port between NREQ drawing
//            requesters using round-robin arbitration (at most one write per
//            cycle). An optional clear engine fills the whole framebuffer
//            with a pattern and has absolute priority over the requesters.
// Macro    : FB_ARB_CLEAR_EN - when defined, the clear engine is built.
//            When undefined, clr_start/clr_pattern are ignored, clr_busy and
//            clr_done are tied low and the arbiter may grant every cycle.
// Ports    : clk          system clock
//            rst_n        synchronous active-low reset
//            req          per-requester write request, held until granted
//            req_addr     packed addresses, requester k at [k*AW +: AW]
//            req_data     packed data, requester k at [k*DW +: DW]
//            gnt          one-hot grant, combinational, same cycle as accept
//            clr_start    pulse: start a full-framebuffer clear
//            clr_pattern  fill value, sampled on an accepted clr_start
//            clr_busy     high while the clear is in progress
//            clr_done     one-cycle pulse after the last clear write issued
//            wr_en        framebuffer write strobe (registered)
//            wr_addr      framebuffer write address (registered)
//            wr_data      framebuffer write data (registered)
// Revision : 1.0 - initial release
// ============================================================================
module fb_write_arbiter #(
  parameter int NREQ  = 4,
  parameter int AW    = 11,
  parameter int DW    = 8,
  parameter int DEPTH = 2048
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*AW-1:0]   req_addr,
  input  logic [NREQ*DW-1:0]   req_data,
  output logic [NREQ-1:0]      gnt,
  input  logic                 clr_start,
  input  logic [DW-1:0]        clr_pattern,
  output logic                 clr_busy,
  output logic                 clr_done,
  output logic                 wr_en,
  output logic [AW-1:0]        wr_addr,
  output logic [DW-1:0]        wr_data
);

  localparam int            PW      = $clog2(NREQ);
  localparam logic [PW-1:0] PTR_RST = PW'(NREQ - 1);
  localparam logic [PW:0]   NREQ_W  = (PW + 1)'(NREQ);

  // --------------------------------------------------------------------------
  // Round-robin search
  // --------------------------------------------------------------------------
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [NREQ-1:0] rr_gnt;
  logic            rr_any;
  logic [PW-1:0]   rr_idx;
  logic [PW:0]     rr_sum;
  logic [AW-1:0]   rr_addr;
  logic [DW-1:0]   rr_data;

  always_comb begin
    rr_gnt  = '0;
    rr_any  = 1'b0;
    rr_idx  = ptr_q;
    rr_sum  = '0;
    rr_addr = '0;
    rr_data = '0;
    // Candidates in order ptr+1, ptr+2, ... wrapping; the sum never exceeds
    // 2*NREQ-1, so a single conditional subtract is the modulo.
    for (int i = 1; i <= NREQ; i++) begin
      rr_sum = {1'b0, ptr_q} + (PW + 1)'(i);
      if (rr_sum >= NREQ_W) begin
        rr_sum = rr_sum - NREQ_W;
      end
      if (!rr_any && req[rr_sum[PW-1:0]]) begin
        rr_any                 = 1'b1;
        rr_idx                 = rr_sum[PW-1:0];
        rr_gnt[rr_sum[PW-1:0]] = 1'b1;
      end
    end
    // One-hot grant selects the winning address/data.
    for (int k = 0; k < NREQ; k++) begin
      if (rr_gnt[k]) begin
        rr_addr = rr_addr | req_addr[k*AW +: AW];
        rr_data = rr_data | req_data[k*DW +: DW];
      end
    end
  end

  // --------------------------------------------------------------------------
  // Clear engine
  // --------------------------------------------------------------------------
  logic          arb_en;    // requesters may be granted this cycle
  logic          clr_wr;    // clear engine issues a write this cycle
  logic [AW-1:0] clr_addr;
  logic [DW-1:0] clr_data;

`ifdef FB_ARB_CLEAR_EN
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CLEAR = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  localparam logic [AW-1:0] CNT_LAST = AW'(DEPTH - 1);

  state_t        state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] pat_q, pat_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      pat_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pat_q   <= pat_d;
    end
  end

  // Address 0 is issued in the start cycle itself (straight from
  // clr_pattern) so it reaches wr_* one cycle later; cnt then holds the next
  // address to issue while in CLEAR.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    pat_d    = pat_q;
    arb_en   = 1'b1;
    clr_wr   = 1'b0;
    clr_addr = cnt_q;
    clr_data = pat_q;
    case (state_q)
      S_IDLE: begin
        if (clr_start) begin
          arb_en   = 1'b0;
          clr_wr   = 1'b1;
          clr_addr = '0;
          clr_data = clr_pattern;
          pat_d    = clr_pattern;
          if (CNT_LAST == '0) begin
            state_d = S_DONE;
          end else begin
            cnt_d   = AW'(1);
            state_d = S_CLEAR;
          end
        end
      end
      S_CLEAR: begin
        arb_en = 1'b0;
        clr_wr = 1'b1;
        if (cnt_q == CNT_LAST) begin
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + AW'(1);
        end
      end
      S_DONE: begin
        // Arbitration is already live here; clr_start is not accepted.
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign clr_busy = (state_q == S_CLEAR);
  assign clr_done = (state_q == S_DONE);
`else
  logic w_unused_clr;

  assign w_unused_clr = ^{clr_start, clr_pattern};
  assign arb_en       = 1'b1;
  assign clr_wr       = 1'b0;
  assign clr_addr     = '0;
  assign clr_data     = '0;
  assign clr_busy     = 1'b0;
  assign clr_done     = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // Grant, pointer and registered write port
  // --------------------------------------------------------------------------
  logic          wr_en_d;
  logic [AW-1:0] wr_addr_d;
  logic [DW-1:0] wr_data_d;

  always_comb begin
    gnt       = arb_en ? rr_gnt : '0;
    ptr_d     = (arb_en && rr_any) ? rr_idx : ptr_q;
    wr_en_d   = clr_wr | (arb_en & rr_any);
    wr_addr_d = clr_wr ? clr_addr : rr_addr;
    wr_data_d = clr_wr ? clr_data : rr_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_q   <= PTR_RST;
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
    end else begin
      ptr_q   <= ptr_d;
      wr_en   <= wr_en_d;
      wr_addr <= wr_addr_d;
      wr_data <= wr_data_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fb_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_fb_write_arbiter
// Purpose  : Self-checking bench for fb_write_arbiter (NREQ=4, AW=11, DW=8,
//            DEPTH=2048). Arbitration vectors come from a table; the clear
//            engine sequences run when FB_ARB_CLEAR_EN is defined, otherwise
//            the tied-off clear behaviour is checked.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fb_write_arbiter;
  localparam int NREQ  = 4;
  localparam int AW    = 11;
  localparam int DW    = 8;
  localparam int DEPTH = 2048;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [NREQ-1:0]     req;
  logic [NREQ*AW-1:0]  req_addr;
  logic [NREQ*DW-1:0]  req_data;
  logic [NREQ-1:0]     gnt;
  logic                clr_start;
  logic [DW-1:0]       clr_pattern;
  logic                clr_busy;
  logic                clr_done;
  logic                wr_en;
  logic [AW-1:0]       wr_addr;
  logic [DW-1:0]       wr_data;

  fb_write_arbiter #(
    .NREQ (NREQ),
    .AW   (AW),
    .DW   (DW),
    .DEPTH(DEPTH)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .req_addr   (req_addr),
    .req_data   (req_data),
    .gnt        (gnt),
    .clr_start  (clr_start),
    .clr_pattern(clr_pattern),
    .clr_busy   (clr_busy),
    .clr_done   (clr_done),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] req;
    logic [3:0] gnt;
  } vec_t;

  vec_t        tbl [13];
  logic [AW-1:0] ea [4];
  logic [DW-1:0] ed [4];
  int          checks   = 0;
  int          failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic pack();
    for (int k = 0; k < NREQ; k++) begin
      req_addr[k*AW +: AW] = ea[k];
      req_data[k*DW +: DW] = ed[k];
    end
  endtask

  function automatic int oh2i(input logic [3:0] g);
    int r = 0;
    for (int k = 0; k < 4; k++) if (g[k]) r = k;
    return r;
  endfunction

  initial begin
    int bad;
    int ndone;
    int idx;

    // Round-robin vectors; pointer starts at 3 so requester 0 leads.
    tbl[0]  = '{4'b1111, 4'b0001};
    tbl[1]  = '{4'b1111, 4'b0010};
    tbl[2]  = '{4'b1111, 4'b0100};
    tbl[3]  = '{4'b1111, 4'b1000};
    tbl[4]  = '{4'b1111, 4'b0001};
    tbl[5]  = '{4'b0000, 4'b0000};
    tbl[6]  = '{4'b0101, 4'b0100};
    tbl[7]  = '{4'b0101, 4'b0001};
    tbl[8]  = '{4'b1001, 4'b1000};
    tbl[9]  = '{4'b0010, 4'b0010};
    tbl[10] = '{4'b0011, 4'b0001};
    tbl[11] = '{4'b1000, 4'b1000};
    tbl[12] = '{4'b0110, 4'b0010};

    ea[0] = 11'h100; ea[1] = 11'h201; ea[2] = 11'h302; ea[3] = 11'h403;
    ed[0] = 8'hA0;   ed[1] = 8'hB1;   ed[2] = 8'hC2;   ed[3] = 8'hD3;
    pack();

    rst_n       = 1'b0;
    req         = 4'b1111;
    clr_start   = 1'b0;
    clr_pattern = 8'h00;

    // T1: reset with all requests pending.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_wr_en",    32'(wr_en),    32'd0);
    chk("rst_wr_addr",  32'(wr_addr),  32'd0);
    chk("rst_wr_data",  32'(wr_data),  32'd0);
    chk("rst_clr_busy", 32'(clr_busy), 32'd0);
    chk("rst_clr_done", 32'(clr_done), 32'd0);

    for (int i = 0; i < 13; i++) begin
      rst_n = 1'b1;
      req   = tbl[i].req;
      #2;
      chk($sformatf("vec%0d_gnt", i), 32'(gnt), 32'(tbl[i].gnt));
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d_wr_en", i), 32'(wr_en), 32'(|tbl[i].gnt));
      if (tbl[i].gnt != 4'b0000) begin
        idx = oh2i(tbl[i].gnt);
        chk($sformatf("vec%0d_wr_addr", i), 32'(wr_addr), 32'(ea[idx]));
        chk($sformatf("vec%0d_wr_data", i), 32'(wr_data), 32'(ed[idx]));
      end
    end

    // T2: single requester 2, then request drops.
    ea[2] = 11'h07F; ed[2] = 8'h80; pack();
    req = 4'b0100;
    #2;
    chk("t2_gnt", 32'(gnt), 32'h4);
    @(posedge clk);
    #1;
    req = 4'b0000;
    chk("t2_wr_en",   32'(wr_en),   32'd1);
    chk("t2_wr_addr", 32'(wr_addr), 32'h07F);
    chk("t2_wr_data", 32'(wr_data), 32'h80);
    #2;
    chk("t2_gnt_idle", 32'(gnt), 32'h0);
    @(posedge clk);
    #1;
    chk("t2_wr_en_off", 32'(wr_en), 32'd0);

`ifdef FB_ARB_CLEAR_EN
    // T3 + T4: clear colliding with a request, restart attempt at addr 1000.
    req         = 4'b0001;
    clr_start   = 1'b1;
    clr_pattern = 8'h00;
    #2;
    chk("t3_gnt_start", 32'(gnt), 32'h0);
    @(posedge clk);
    #1;
    clr_start = 1'b0;
    bad   = 0;
    ndone = 0;
    for (int j = 1; j <= DEPTH; j++) begin
      #1;
      if (wr_en !== 1'b1 || wr_addr !== AW'(j - 1) || wr_data !== 8'h00) bad++;
      if (gnt !== ((j == DEPTH) ? 4'b0001 : 4'b0000)) bad++;
      if (clr_busy !== (j < DEPTH)) bad++;
      if (clr_done === 1'b1) ndone++;
      if (clr_done !== (j == DEPTH)) bad++;
      clr_start = (j == 1001);
      @(posedge clk);
      #1;
    end
    req = 4'b0000;
    #1;
    chk("t3_seq_errors",  32'(bad),     32'd0);
    chk("t3_post_wr_en",  32'(wr_en),   32'd1);
    chk("t3_post_addr",   32'(wr_addr), 32'(ea[0]));
    chk("t3_post_data",   32'(wr_data), 32'(ed[0]));
    if (clr_done === 1'b1) ndone++;
    @(posedge clk);
    #2;
    if (clr_done === 1'b1) ndone++;
    chk("t3_idle_wr_en",  32'(wr_en),    32'd0);
    chk("t3_idle_busy",   32'(clr_busy), 32'd0);
    chk("t4_done_count",  32'(ndone),    32'd1);

    // T5: reset in the middle of a clear, then restart.
    clr_start   = 1'b1;
    clr_pattern = 8'h5A;
    @(posedge clk);
    #1;
    clr_start = 1'b0;
    bad = 0;
    for (int j = 1; j <= 501; j++) begin
      #1;
      if (wr_en !== 1'b1 || wr_addr !== AW'(j - 1) || wr_data !== 8'h5A) bad++;
      if (j < 501) begin
        @(posedge clk);
        #1;
      end
    end
    chk("t5_seq_errors", 32'(bad), 32'd0);
    rst_n = 1'b0;
    @(posedge clk);
    #2;
    chk("t5_rst_busy",  32'(clr_busy), 32'd0);
    chk("t5_rst_wr_en", 32'(wr_en),    32'd0);
    chk("t5_rst_done",  32'(clr_done), 32'd0);
    rst_n = 1'b1;
    ndone = 0;
    repeat (4) begin
      @(posedge clk);
      #2;
      if (clr_done === 1'b1) ndone++;
    end
    chk("t5_no_done", 32'(ndone), 32'd0);
    clr_start   = 1'b1;
    clr_pattern = 8'hC3;
    @(posedge clk);
    #2;
    clr_start = 1'b0;
    chk("t5_restart_wr_en", 32'(wr_en),    32'd1);
    chk("t5_restart_addr",  32'(wr_addr),  32'd0);
    chk("t5_restart_data",  32'(wr_data),  32'hC3);
    chk("t5_restart_busy",  32'(clr_busy), 32'd1);
    @(posedge clk);
    #2;
    chk("t5_restart_addr1", 32'(wr_addr), 32'd1);
`else
    // T6: clear engine absent; clr_start has no effect on arbitration.
    req         = 4'b0010;
    clr_start   = 1'b1;
    clr_pattern = 8'hFF;
    #2;
    chk("t6_gnt",  32'(gnt),      32'h2);
    chk("t6_busy", 32'(clr_busy), 32'd0);
    chk("t6_done", 32'(clr_done), 32'd0);
    @(posedge clk);
    #1;
    clr_start = 1'b0;
    req       = 4'b0000;
    chk("t6_wr_en",   32'(wr_en),    32'd1);
    chk("t6_wr_addr", 32'(wr_addr),  32'(ea[1]));
    chk("t6_wr_data", 32'(wr_data),  32'(ed[1]));
    chk("t6_busy2",   32'(clr_busy), 32'd0);
    chk("t6_done2",   32'(clr_done), 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
